// File: rtl/sal_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sal_cmd_arbiter
//
// Per-channel DRAM command scheduler. Each cycle it picks at most one command
// from NUM_BANKS per-bank controllers plus the refresh controller. It enforces
// the inter-bank timing windows (tRRD, tCCD, tWTR, tRTW, tRFC) and drives
// one-hot grants with ba/ra/ca to the command encoder, which registers them.
//
// Ports
//   clk       clock
//   rst       asynchronous reset, active-high
//   act_req   per-bank ACT request, held until bank_gnt
//   rd_req    per-bank RD request
//   wr_req    per-bank WR request
//   pre_req   per-bank PRE request
//   ra_in     row address per bank, bank b at [b*RA_W +: RA_W]
//   ca_in     column address per bank, bank b at [b*CA_W +: CA_W]
//   ref_req   refresh request (all banks already precharged by requester)
//   bank_gnt  one-hot bank granted this cycle (zero on REF or idle)
//   ref_gnt   REF granted
//   act_gnt   ACT granted
//   rd_gnt    RD granted
//   wr_gnt    WR granted
//   pre_gnt   PRE granted
//   ba        granted bank, 0 when no bank grant
//   ra        row address of the granted bank on ACT, else 0
//   ca        column address of the granted bank on RD/WR, else 0
// ---------------------------------------------------------------------------
module sal_cmd_arbiter #(
    parameter int NUM_BANKS = 8,
    parameter int BA_W      = 3,
    parameter int RA_W      = 16,
    parameter int CA_W      = 11,
    parameter int CNT_W     = 8,
    parameter int T_RRD     = 4,
    parameter int T_CCD     = 4,
    parameter int T_WTR     = 12,
    parameter int T_RTW     = 8,
    parameter int T_RFC     = 88
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BANKS-1:0]      act_req,
    input  logic [NUM_BANKS-1:0]      rd_req,
    input  logic [NUM_BANKS-1:0]      wr_req,
    input  logic [NUM_BANKS-1:0]      pre_req,
    input  logic [NUM_BANKS*RA_W-1:0] ra_in,
    input  logic [NUM_BANKS*CA_W-1:0] ca_in,
    input  logic                      ref_req,
    output logic [NUM_BANKS-1:0]      bank_gnt,
    output logic                      ref_gnt,
    output logic                      act_gnt,
    output logic                      rd_gnt,
    output logic                      wr_gnt,
    output logic                      pre_gnt,
    output logic [BA_W-1:0]           ba,
    output logic [RA_W-1:0]           ra,
    output logic [CA_W-1:0]           ca
);

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_REF,
        CMD_RD,
        CMD_WR,
        CMD_ACT,
        CMD_PRE
    } cmd_e;

    typedef struct packed {
        logic            hit;
        logic [BA_W-1:0] idx;
    } pick_t;

    // A command at cycle c makes the constrained command legal again at c+T,
    // so the counter is loaded with T-1 and must reach zero first.
    localparam logic [CNT_W-1:0] LD_RRD = CNT_W'(T_RRD - 1);
    localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] LD_WTR = CNT_W'(T_WTR - 1);
    localparam logic [CNT_W-1:0] LD_RTW = CNT_W'(T_RTW - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);

    // Round-robin pick: first set bit at ptr, ptr+1, ... (mod NUM_BANKS).
    // Scanning from the far end lets the nearest candidate overwrite the rest;
    // the BA_W-bit sum wraps on its own because NUM_BANKS is a power of two.
    function automatic pick_t rr_pick(input logic [NUM_BANKS-1:0] elig,
                                      input logic [BA_W-1:0]      ptr);
        pick_t           p;
        logic [BA_W-1:0] b;
        p = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            b = ptr + BA_W'(i);
            if (elig[b]) begin
                p.hit = 1'b1;
                p.idx = b;
            end
        end
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] c_rrd, c_ccd, c_wtr, c_rtw, c_rfc;
    logic [BA_W-1:0]  rr_ptr;

    logic             rd_ok, wr_ok, act_ok;
    logic [NUM_BANKS-1:0] cas_bank, act_bank, pre_bank, cas_elig, act_elig;
    pick_t            cas_pick, act_pick, pre_pick;
    cmd_e             cmd;
    logic [BA_W-1:0]  sel;
    logic             bank_cmd;

    assign rd_ok  = (c_ccd == '0) && (c_wtr == '0);
    assign wr_ok  = (c_ccd == '0) && (c_rtw == '0);
    assign act_ok = (c_rrd == '0);

    // Each bank competes only in its highest requested class, even when that
    // class is currently timing-blocked; RD beats WR inside the same bank.
    assign cas_bank = rd_req | wr_req;
    assign act_bank = act_req & ~cas_bank;
    assign pre_bank = pre_req & ~act_req & ~cas_bank;

    assign cas_elig = (rd_req & {NUM_BANKS{rd_ok}})
                    | (wr_req & ~rd_req & {NUM_BANKS{wr_ok}});
    assign act_elig = act_bank & {NUM_BANKS{act_ok}};

    assign cas_pick = rr_pick(cas_elig, rr_ptr);
    assign act_pick = rr_pick(act_elig, rr_ptr);
    assign pre_pick = rr_pick(pre_bank, rr_ptr);

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        cmd = CMD_NONE;
        sel = '0;
        // Nothing issues during tRFC. A pending refresh with tRFC expired wins
        // outright; a blocked class falls through to the next lower one.
        if (!rst && (c_rfc == '0)) begin
            if (ref_req) begin
                cmd = CMD_REF;
            end else if (cas_pick.hit) begin
                sel = cas_pick.idx;
                cmd = rd_req[cas_pick.idx] ? CMD_RD : CMD_WR;
            end else if (act_pick.hit) begin
                sel = act_pick.idx;
                cmd = CMD_ACT;
            end else if (pre_pick.hit) begin
                sel = pre_pick.idx;
                cmd = CMD_PRE;
            end
        end
    end

    // A refresh also holds off everything while tRFC is still running; that
    // case already lands in CMD_NONE above because c_rfc is nonzero.

    assign ref_gnt  = (cmd == CMD_REF);
    assign act_gnt  = (cmd == CMD_ACT);
    assign rd_gnt   = (cmd == CMD_RD);
    assign wr_gnt   = (cmd == CMD_WR);
    assign pre_gnt  = (cmd == CMD_PRE);
    assign bank_cmd = act_gnt | rd_gnt | wr_gnt | pre_gnt;

    assign bank_gnt = bank_cmd ? (NUM_BANKS'(1) << sel) : '0;
    assign ba       = bank_cmd ? sel : '0;
    assign ra       = act_gnt ? ra_in[int'(sel)*RA_W +: RA_W] : '0;
    assign ca       = (rd_gnt | wr_gnt) ? ca_in[int'(sel)*CA_W +: CA_W] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rrd  <= '0;
            c_ccd  <= '0;
            c_wtr  <= '0;
            c_rtw  <= '0;
            c_rfc  <= '0;
            rr_ptr <= '0;
        end else begin
            c_rrd <= act_gnt           ? LD_RRD : dec_sat(c_rrd);
            c_ccd <= (rd_gnt | wr_gnt) ? LD_CCD : dec_sat(c_ccd);
            c_wtr <= wr_gnt            ? LD_WTR : dec_sat(c_wtr);
            c_rtw <= rd_gnt            ? LD_RTW : dec_sat(c_rtw);
            c_rfc <= ref_gnt           ? LD_RFC : dec_sat(c_rfc);
            if (bank_cmd) begin
                rr_ptr <= sel + BA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sal_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sal_cmd_arbiter
//
// Directed bench for sal_cmd_arbiter with default parameters. Inputs change
// 1 time unit after the rising edge; grant outputs are combinational and are
// compared at the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_sal_cmd_arbiter;

    localparam int NB   = 8;
    localparam int BA_W = 3;
    localparam int RA_W = 16;
    localparam int CA_W = 11;
    localparam int OW   = 5 + NB + BA_W + RA_W + CA_W;

    // Grant codes in {ref, act, rd, wr, pre} order.
    localparam logic [4:0] G_NONE = 5'b00000;
    localparam logic [4:0] G_REF  = 5'b10000;
    localparam logic [4:0] G_ACT  = 5'b01000;
    localparam logic [4:0] G_RD   = 5'b00100;
    localparam logic [4:0] G_WR   = 5'b00010;
    localparam logic [4:0] G_PRE  = 5'b00001;

    logic                 clk;
    logic                 rst;
    logic [NB-1:0]        act_req, rd_req, wr_req, pre_req;
    logic [NB*RA_W-1:0]   ra_in;
    logic [NB*CA_W-1:0]   ca_in;
    logic                 ref_req;
    logic [NB-1:0]        bank_gnt;
    logic                 ref_gnt, act_gnt, rd_gnt, wr_gnt, pre_gnt;
    logic [BA_W-1:0]      ba;
    logic [RA_W-1:0]      ra;
    logic [CA_W-1:0]      ca;

    int errors = 0;
    int checks = 0;

    sal_cmd_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .act_req  (act_req),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .pre_req  (pre_req),
        .ra_in    (ra_in),
        .ca_in    (ca_in),
        .ref_req  (ref_req),
        .bank_gnt (bank_gnt),
        .ref_gnt  (ref_gnt),
        .act_gnt  (act_gnt),
        .rd_gnt   (rd_gnt),
        .wr_gnt   (wr_gnt),
        .pre_gnt  (pre_gnt),
        .ba       (ba),
        .ra       (ra),
        .ca       (ca)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct per-bank address patterns so a wrong bank slice is visible.
    function automatic logic [RA_W-1:0] ra_of(input int b);
        return 16'hA500 + RA_W'(b * 3 + 1);
    endfunction

    function automatic logic [CA_W-1:0] ca_of(input int b);
        return 11'h300 + CA_W'(b * 5 + 2);
    endfunction

    function automatic logic [OW-1:0] obs();
        return {ref_gnt, act_gnt, rd_gnt, wr_gnt, pre_gnt, bank_gnt, ba, ra, ca};
    endfunction

    // Expected output vector for grant code g on bank (bank < 0: no bank).
    function automatic logic [OW-1:0] mk(input logic [4:0] g, input int bank);
        logic [NB-1:0]   bg;
        logic [BA_W-1:0] b;
        logic [RA_W-1:0] r;
        logic [CA_W-1:0] c;
        bg = '0;
        b  = '0;
        r  = '0;
        c  = '0;
        if (bank >= 0) begin
            b  = BA_W'(bank);
            bg = NB'(1) << bank;
            if (g == G_ACT) r = ra_of(bank);
            if (g == G_RD || g == G_WR) c = ca_of(bank);
        end
        return {g, bg, b, r, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        act_req = '0;
        rd_req  = '0;
        wr_req  = '0;
        pre_req = '0;
        ref_req = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset forces outputs low with everything requesting; REF wins first
    // after release; reset in the middle of tRFC clears the refresh window.
    task automatic test_reset();
        logic [OW-1:0] e;
        rst     = 1'b1;
        act_req = '1;
        rd_req  = '1;
        wr_req  = '1;
        pre_req = '1;
        ref_req = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", obs(), {OW{1'b0}});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        e = mk(G_REF, -1);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_first_ref: got %h want %h", obs(), e);
        end
        tick();
        clear_reqs();
        rd_req = 8'h08;
        @(negedge clk);
        e = mk(G_NONE, -1);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_trfc_block: got %h want %h", obs(), e);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_async_mid_trfc: got %h want %h", obs(), {OW{1'b0}});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        e = mk(G_RD, 3);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_trfc_cleared: got %h want %h", obs(), e);
        end
        do_reset();
    endtask

    // Two ACTs back-to-back are spaced by tRRD = 4.
    task automatic test_act_rrd();
        logic [OW-1:0] e;
        do_reset();
        act_req = 8'b0000_0011;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            e = (c == 0) ? mk(G_ACT, 0) : (c == 4) ? mk(G_ACT, 1) : mk(G_NONE, -1);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL act_rrd c%0d: got %h want %h", c, obs(), e);
            end
            tick();
            if (c == 0) act_req[0] = 1'b0;
            if (c == 4) act_req[1] = 1'b0;
        end
    endtask

    // Round-robin between RD banks 2 and 5, spaced by tCCD = 4.
    task automatic test_rd_rr();
        logic [OW-1:0] e;
        do_reset();
        rd_req = 8'b0010_0100;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            e = (c == 4) ? mk(G_RD, 5) : (c % 4 == 0) ? mk(G_RD, 2) : mk(G_NONE, -1);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL rd_rr c%0d: got %h want %h", c, obs(), e);
            end
            tick();
        end
        clear_reqs();
    endtask

    // WR->RD waits tWTR = 12, RD->WR waits tRTW = 8, RD beats WR in one bank.
    task automatic test_turnaround();
        logic [OW-1:0] e;
        do_reset();
        wr_req = 8'h01;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            e = (c == 0) ? mk(G_WR, 0) : (c == 12) ? mk(G_RD, 1) : mk(G_NONE, -1);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL wtr c%0d: got %h want %h", c, obs(), e);
            end
            tick();
            if (c == 0) begin
                wr_req = '0;
                rd_req = 8'h02;
            end
            if (c == 12) rd_req = '0;
        end
        do_reset();
        rd_req = 8'h02;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            e = (c == 0) ? mk(G_RD, 1) : (c == 8) ? mk(G_WR, 0) : mk(G_NONE, -1);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL rtw c%0d: got %h want %h", c, obs(), e);
            end
            tick();
            if (c == 0) begin
                rd_req = '0;
                wr_req = 8'h01;
            end
            if (c == 8) wr_req = '0;
        end
        do_reset();
        rd_req = 8'h10;
        wr_req = 8'h10;
        @(negedge clk);
        e = mk(G_RD, 4);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rd_over_wr: got %h want %h", obs(), e);
        end
        tick();
        clear_reqs();
    endtask

    // REF wins over a pending RD, then nothing issues for tRFC = 88 cycles.
    task automatic test_ref_block();
        logic [OW-1:0] e;
        do_reset();
        ref_req = 1'b1;
        rd_req  = 8'h08;
        for (int c = 0; c <= 88; c++) begin
            @(negedge clk);
            e = (c == 0) ? mk(G_REF, -1) : (c == 88) ? mk(G_RD, 3) : mk(G_NONE, -1);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL ref_block c%0d: got %h want %h", c, obs(), e);
            end
            tick();
            if (c == 0) ref_req = 1'b0;
            if (c == 88) rd_req = '0;
        end
    endtask

    // Class ordering RD > ACT > PRE, ACT during tCCD, PRE during tRRD, and an
    // asynchronous reset in the middle of the burst.
    task automatic test_class_mix();
        logic [OW-1:0] e;
        do_reset();
        rd_req  = 8'h08;
        act_req = 8'h02;
        pre_req = 8'h40;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            case (c)
                0:       e = mk(G_RD, 3);
                1:       e = mk(G_ACT, 1);
                2:       e = mk(G_PRE, 6);
                default: e = mk(G_NONE, -1);
            endcase
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL class_mix c%0d: got %h want %h", c, obs(), e);
            end
            tick();
            if (c == 0) rd_req = '0;
            if (c == 1) act_req = '0;
            if (c == 2) pre_req = '0;
        end
        // ACT requests on banks 1 and 5: without the reset rr_ptr would be 4
        // after the RD to bank 3 and bank 5 would win.
        do_reset();
        rd_req  = 8'h08;
        act_req = 8'h22;
        pre_req = 8'h40;
        @(negedge clk);
        e = mk(G_RD, 3);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL mid_burst_rd: got %h want %h", obs(), e);
        end
        tick();
        rd_req = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset: got %h want %h", obs(), {OW{1'b0}});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        e = mk(G_ACT, 1);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL mid_burst_act: got %h want %h", obs(), e);
        end
        tick();
        act_req = 8'h20;
        @(negedge clk);
        e = mk(G_PRE, 6);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL mid_burst_pre: got %h want %h", obs(), e);
        end
        tick();
        clear_reqs();
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        for (int b = 0; b < NB; b++) begin
            ra_in[b*RA_W +: RA_W] = ra_of(b);
            ca_in[b*CA_W +: CA_W] = ca_of(b);
        end
        test_reset();
        test_act_rrd();
        test_rd_rr();
        test_turnaround();
        test_ref_block();
        test_class_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
